// File: rtl/pipe_stage_latch.sv
// Pipeline-boundary register chain: DEPTH slots of {valid, ctrl, data} with
// hold/bubble/flush control, occupancy tracking and saturating perf counters.
module pipe_stage_latch #(
  parameter int                CTRL_W   = 20,
  parameter int                DATA_W   = 192,
  parameter int                DEPTH    = 1,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [2:0]        occ_d;
  logic              bubble_inc, stall_inc;
  logic [CNT_W-1:0]  bubble_cnt_d, stall_cnt_d;

  // Flush keeps data in place; only valid and ctrl are killed.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (flush) begin
      vld_d = '0;
      for (int i = 0; i < DEPTH; i++) ctrl_d[i] = NOP_CTRL;
    end else if (!hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1];
        ctrl_d[i] = ctrl_q[i-1];
        data_d[i] = data_q[i-1];
      end
      if (bubble) begin
        vld_d[0]  = 1'b0;
        ctrl_d[0] = NOP_CTRL;
      end else begin
        vld_d[0]  = in_valid;
        ctrl_d[0] = in_valid ? in_ctrl : NOP_CTRL;
        data_d[0] = in_data;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + 3'(vld_d[i]);
  end

  assign bubble_inc = flush | (~hold & (bubble | ~in_valid));
  assign stall_inc  = hold & ~flush & vld_q[DEPTH-1];

  // Clear beats increment; counters stick at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt;
    stall_cnt_d  = stall_cnt;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      stall_cnt_d  = '0;
    end else begin
      if (bubble_inc && bubble_cnt != '1) bubble_cnt_d = bubble_cnt + 1'b1;
      if (stall_inc && stall_cnt != '1)   stall_cnt_d  = stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= NOP_CTRL;
        data_q[i] <= '0;
      end
      occupancy  <= '0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= ctrl_d[i];
        data_q[i] <= data_d[i];
      end
      occupancy  <= occ_d;
      bubble_cnt <= bubble_cnt_d;
      stall_cnt  <= stall_cnt_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_stage_latch;
  localparam int          CTRL_W = 12;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 3;
  localparam int          CNT_W  = 4;
  localparam logic [11:0] NOP    = 12'h05A;
  localparam int          SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, hold, bubble, flush, cnt_clr;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_latch #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_CTRL(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .hold(hold), .bubble(bubble), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the chain as a plain array of entries, output = oldest entry.
  bit          m_v [DEPTH];
  logic [11:0] m_c [DEPTH];
  logic [31:0] m_d [DEPTH];
  int          m_b, m_s;

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_v[i] = 1'b0; m_c[i] = NOP; m_d[i] = '0;
      end
      m_b = 0; m_s = 0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_v[i] = 1'b0; m_c[i] = NOP;
        end
        m_b = m_b + 1;
      end else if (hold) begin
        if (m_v[DEPTH-1]) m_s = m_s + 1;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_c[i] = m_c[i-1]; m_d[i] = m_d[i-1];
        end
        if (bubble) begin
          m_v[0] = 1'b0; m_c[0] = NOP;
        end else begin
          m_v[0] = in_valid; m_c[0] = in_valid ? in_ctrl : NOP; m_d[0] = in_data;
        end
        if (!m_v[0]) m_b = m_b + 1;
      end
      if (m_b > SAT) m_b = SAT;
      if (m_s > SAT) m_s = SAT;
      if (cnt_clr) begin
        m_b = 0; m_s = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_out_valid", {63'd0, out_valid}, {63'd0, m_v[DEPTH-1]});
      chk("model_out_ctrl", 64'(out_ctrl), 64'(m_c[DEPTH-1]));
      chk("model_out_data", 64'(out_data), 64'(m_d[DEPTH-1]));
      chk("model_occupancy", 64'(occupancy), 64'(m_occ()));
      chk("model_bubble_cnt", 64'(bubble_cnt), 64'(m_b));
      chk("model_stall_cnt", 64'(stall_cnt), 64'(m_s));
    end
  end

  task automatic drive(input bit v, input logic [11:0] c, input logic [31:0] d,
                       input bit h, input bit b, input bit f, input bit clr);
    in_valid = v; in_ctrl = c; in_data = d; hold = h; bubble = b; flush = f; cnt_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_ctrl = '0; in_data = '0; hold = 0; bubble = 0; flush = 0; cnt_clr = 0;
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("reset_counters", {56'd0, bubble_cnt, stall_cnt}, 64'd0);
    rst = 1'b0;

    // Load with latency DEPTH edges, back-to-back occupancy growth
    drive(1, 12'h0A5, 32'h1234, 0, 0, 0, 0);
    chk("load_occ1", 64'(occupancy), 64'd1);
    chk("load_not_yet_out", {63'd0, out_valid}, 64'd0);
    drive(1, 12'h111, 32'h0002, 0, 0, 0, 0);
    chk("load_occ2", 64'(occupancy), 64'd2);
    drive(0, 12'h777, 32'h0000, 0, 0, 0, 0);
    chk("load_out_valid", {63'd0, out_valid}, 64'd1);
    chk("load_out_ctrl", 64'(out_ctrl), 64'h0A5);
    chk("load_out_data", 64'(out_data), 64'h1234);
    chk("load_bubble_cnt", 64'(bubble_cnt), 64'd1);

    // Hold three edges while inputs wander
    for (int i = 0; i < 3; i++) drive(1, 12'(i + 1), 32'(i + 100), 1, i[0], 0, 0);
    chk("hold_out_ctrl", 64'(out_ctrl), 64'h0A5);
    chk("hold_out_data", 64'(out_data), 64'h1234);
    chk("hold_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("hold_bubble_cnt", 64'(bubble_cnt), 64'd1);
    drive(0, 12'h000, 32'h0, 0, 0, 0, 0);
    chk("release_out_ctrl", 64'(out_ctrl), 64'h111);
    chk("release_out_data", 64'(out_data), 64'h2);
    drive(0, 12'h000, 32'h0, 0, 0, 0, 0);
    chk("release_out_nop", 64'(out_ctrl), 64'(NOP));
    chk("release_bubble_cnt", 64'(bubble_cnt), 64'd3);

    // Fill, then flush+hold+bubble together
    drive(1, 12'h0B1, 32'hA1, 0, 0, 0, 0);
    drive(1, 12'h0B2, 32'hA2, 0, 0, 0, 0);
    drive(1, 12'h0B3, 32'hA3, 0, 0, 0, 0);
    chk("fill_occ3", 64'(occupancy), 64'd3);
    drive(1, 12'h0C0, 32'hC0, 1, 1, 1, 0);
    chk("flush_occ0", 64'(occupancy), 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("flush_data_kept", 64'(out_data), 64'hA1);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("flush_bubble_cnt", 64'(bubble_cnt), 64'd4);

    // Bubble+hold: hold wins, no bubble counted
    drive(1, 12'h3FF, 32'h55, 1, 1, 0, 0);
    chk("bubhold_bubble_cnt", 64'(bubble_cnt), 64'd4);
    // Bubble with a live input, then the same input loads
    drive(1, 12'h3FF, 32'h66, 0, 1, 0, 0);
    drive(1, 12'h3FF, 32'h77, 0, 0, 0, 0);
    drive(0, 12'h3FF, 32'h0, 0, 0, 0, 0);
    drive(0, 12'h3FF, 32'h0, 0, 0, 0, 0);
    chk("bubble_then_load_ctrl", 64'(out_ctrl), 64'h3FF);
    chk("bubble_then_load_data", 64'(out_data), 64'h77);

    // Saturation, then clear beating a simultaneous bubble
    for (int i = 0; i < 20; i++) drive(1, 12'h1, 32'h1, 0, 1, 0, 0);
    chk("sat_bubble_cnt", 64'(bubble_cnt), 64'(SAT));
    drive(1, 12'h1, 32'h1, 0, 1, 0, 1);
    chk("clr_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);

    // Async reset mid-stream, between clock edges
    for (int i = 0; i < DEPTH; i++) drive(1, 12'h0A5, 32'hBEEF, 0, 0, 0, 0);
    drive(1, 12'h0A5, 32'hBEEF, 1, 0, 0, 0);
    chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("async_rst_out_data", 64'(out_data), 64'd0);
    chk("async_rst_occ", 64'(occupancy), 64'd0);
    chk("async_rst_counters", {56'd0, bubble_cnt, stall_cnt}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic, compared every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(3) != 0);
      in_ctrl  = 12'($urandom);
      in_data  = $urandom;
      hold     = ($urandom_range(4) == 0);
      bubble   = ($urandom_range(7) == 0);
      flush    = ($urandom_range(15) == 0);
      cnt_clr  = ($urandom_range(39) == 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
